// File: rtl/spa_pkg.sv
// Shared types and constants for the scratchpad access sequencer (spa_seq).
// The optional write-verify pass is enabled by the SPA_WRITE_VERIFY_EN macro.
package spa_pkg;

    localparam logic [1:0] SPA_BANK_TMP = 2'b00;
    localparam logic [1:0] SPA_BANK_GPR = 2'b01;
    localparam logic [1:0] SPA_BANK_IPR = 2'b10;
    localparam logic [1:0] SPA_BANK_ILL = 2'b11;

    localparam logic [1:0] SPA_ERR_NONE   = 2'b00;
    localparam logic [1:0] SPA_ERR_BANK   = 2'b01;
    localparam logic [1:0] SPA_ERR_VERIFY = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_W_SETUP,
        ST_W_PULSE,
        ST_W_HOLD,
        ST_V_ADDR,
        ST_V_DATA
    } spa_state_e;

    typedef struct packed {
        logic        wr;
        logic [1:0]  bank;
        logic [3:0]  addr;
        logic [3:0]  be;
        logic [31:0] data;
    } spa_req_t;

    // Active-low chip selects ordered {tmp, gpr, ipr}; the illegal bank selects nothing.
    function automatic logic [2:0] spa_cs_l(input logic [1:0] bank);
        case (bank)
            SPA_BANK_TMP: spa_cs_l = 3'b011;
            SPA_BANK_GPR: spa_cs_l = 3'b101;
            SPA_BANK_IPR: spa_cs_l = 3'b110;
            default:      spa_cs_l = 3'b111;
        endcase
    endfunction

    function automatic logic [31:0] spa_be_mask(input logic [3:0] be);
        spa_be_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/spa_arb.sv
// Two-way requester arbiter: micro has priority, but a console request that has
// watched CON_STARVE consecutive micro grants wins the next arbitration.
module spa_arb #(
    parameter int CON_STARVE = 4
) (
    input  logic clk_h,
    input  logic reset_l,
    input  logic i_en,
    input  logic i_mreq,
    input  logic i_creq,
    output logic o_gnt,
    output logic o_src
);

    localparam logic [3:0] STARVE_MAX = 4'(CON_STARVE);

    logic [3:0] r_starve;
    logic       w_con_due;

    assign w_con_due = (r_starve == STARVE_MAX);
    assign o_gnt     = i_en && (i_mreq || i_creq);
    assign o_src     = i_creq && (!i_mreq || w_con_due);

    always_ff @(posedge clk_h) begin
        if (!reset_l) begin
            r_starve <= 4'd0;
        end else if (o_gnt) begin
            if (o_src) begin
                r_starve <= 4'd0;
            end else if (i_creq && !w_con_due) begin
                r_starve <= r_starve + 4'd1;
            end
        end
    end

endmodule

// File: rtl/spa_seq.sv
// Scratchpad access sequencer: arbitrates micro/console requests and drives the
// async 16x4 RAM strobes. Define SPA_WRITE_VERIFY_EN for a read-back check after writes.
module spa_seq
    import spa_pkg::*;
#(
    parameter int CON_STARVE = 4
) (
    input  logic        clk_h,
    input  logic        reset_l,
    input  logic        mreq_h,
    input  logic        mwr_h,
    input  logic [1:0]  mbank_h,
    input  logic [3:0]  maddr_h,
    input  logic [3:0]  mbe_h,
    input  logic [31:0] mdata_h,
    output logic        mack_h,
    input  logic        creq_h,
    input  logic        cwr_h,
    input  logic [1:0]  cbank_h,
    input  logic [3:0]  caddr_h,
    input  logic [3:0]  cbe_h,
    input  logic [31:0] cdata_h,
    output logic        cack_h,
    output logic [31:0] rdata_h,
    output logic        rvalid_h,
    output logic        rsrc_h,
    output logic        busy_h,
    output logic        err_h,
    output logic [1:0]  errcode_h,
    output logic [3:0]  rspa_h,
    output logic [31:0] wbus_h,
    output logic [3:0]  spw_l,
    output logic        rcs_tmp_l,
    output logic        rcs_gpr_l,
    output logic        rcs_ipr_l,
    input  logic [31:0] rbus_l
);

    spa_state_e  r_state, w_state_next;
    logic [1:0]  r_bank;
    logic [3:0]  r_be;
    logic        r_src;
    logic [3:0]  r_rspa;
    logic [31:0] r_wbus;
    logic [31:0] r_rdata;
    logic        r_rvalid;
    logic        r_rsrc;
    logic        r_err;
    logic [1:0]  r_errcode;

    logic        w_gnt, w_src, w_cs_on;
    logic [2:0]  w_rcs_l;
    logic [3:0]  w_spw_l;
    spa_req_t    w_sel;

    spa_arb #(.CON_STARVE(CON_STARVE)) u_arb (
        .clk_h  (clk_h),
        .reset_l(reset_l),
        .i_en   (r_state == ST_IDLE),
        .i_mreq (mreq_h),
        .i_creq (creq_h),
        .o_gnt  (w_gnt),
        .o_src  (w_src)
    );

    assign w_sel = w_src ? {cwr_h, cbank_h, caddr_h, cbe_h, cdata_h}
                         : {mwr_h, mbank_h, maddr_h, mbe_h, mdata_h};

`ifdef SPA_WRITE_VERIFY_EN
    logic w_vfy_bad;
    assign w_vfy_bad = |((~rbus_l ^ r_wbus) & spa_be_mask(r_be));
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt && (w_sel.bank != SPA_BANK_ILL)) begin
                    w_state_next = w_sel.wr ? ST_W_SETUP : ST_RD_ADDR;
                end
            end
            ST_RD_ADDR: w_state_next = ST_RD_DATA;
            ST_RD_DATA: w_state_next = ST_IDLE;
            ST_W_SETUP: w_state_next = ST_W_PULSE;
            ST_W_PULSE: w_state_next = ST_W_HOLD;
            ST_W_HOLD: begin
`ifdef SPA_WRITE_VERIFY_EN
                w_state_next = (r_be != 4'b0000) ? ST_V_ADDR : ST_IDLE;
`else
                w_state_next = ST_IDLE;
`endif
            end
            ST_V_ADDR:  w_state_next = ST_V_DATA;
            ST_V_DATA:  w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // Strobes decode straight from state so a reset edge releases them immediately.
    always_comb begin
        w_cs_on = (r_state == ST_RD_ADDR) || (r_state == ST_RD_DATA) ||
                  (r_state == ST_W_PULSE) ||
                  (r_state == ST_V_ADDR)  || (r_state == ST_V_DATA);
        w_rcs_l = w_cs_on ? spa_cs_l(r_bank) : 3'b111;
        w_spw_l = (r_state == ST_W_PULSE) ? ~r_be : 4'hF;
    end

    always_ff @(posedge clk_h) begin
        if (!reset_l) begin
            r_state   <= ST_IDLE;
            r_bank    <= SPA_BANK_TMP;
            r_be      <= 4'h0;
            r_src     <= 1'b0;
            r_rspa    <= 4'h0;
            r_wbus    <= 32'h0;
            r_rdata   <= 32'h0;
            r_rvalid  <= 1'b0;
            r_rsrc    <= 1'b0;
            r_err     <= 1'b0;
            r_errcode <= SPA_ERR_NONE;
        end else begin
            r_state   <= w_state_next;
            r_rvalid  <= 1'b0;
            r_err     <= 1'b0;
            r_errcode <= SPA_ERR_NONE;
            if (w_gnt) begin
                r_src <= w_src;
                if (w_sel.bank == SPA_BANK_ILL) begin
                    r_err     <= 1'b1;
                    r_errcode <= SPA_ERR_BANK;
                    r_rsrc    <= w_src;
                end else begin
                    r_bank <= w_sel.bank;
                    r_be   <= w_sel.be;
                    r_rspa <= w_sel.addr;
                    if (w_sel.wr) begin
                        r_wbus <= w_sel.data;
                    end
                end
            end
            if (r_state == ST_RD_DATA) begin
                r_rdata  <= ~rbus_l;
                r_rvalid <= 1'b1;
                r_rsrc   <= r_src;
            end
`ifdef SPA_WRITE_VERIFY_EN
            if ((r_state == ST_V_DATA) && w_vfy_bad) begin
                r_err     <= 1'b1;
                r_errcode <= SPA_ERR_VERIFY;
                r_rsrc    <= r_src;
            end
`endif
        end
    end

    assign mack_h    = w_gnt && !w_src;
    assign cack_h    = w_gnt && w_src;
    assign busy_h    = (r_state != ST_IDLE);
    assign rdata_h   = r_rdata;
    assign rvalid_h  = r_rvalid;
    assign rsrc_h    = r_rsrc;
    assign err_h     = r_err;
    assign errcode_h = r_errcode;
    assign rspa_h    = r_rspa;
    assign wbus_h    = r_wbus;
    assign spw_l     = w_spw_l;
    assign rcs_tmp_l = w_rcs_l[2];
    assign rcs_gpr_l = w_rcs_l[1];
    assign rcs_ipr_l = w_rcs_l[0];

endmodule

// File: tb/tb_spa_seq.sv
// Self-checking bench for spa_seq: an async-RAM model on the strobes plus a
// transaction-level memory reference; honours SPA_WRITE_VERIFY_EN if defined.
module tb_spa_seq;

    localparam int CON_STARVE = 4;
`ifdef SPA_WRITE_VERIFY_EN
    localparam bit VFY = 1'b1;
`else
    localparam bit VFY = 1'b0;
`endif

    logic        clk_h = 1'b0;
    logic        reset_l;
    logic        mreq_h, mwr_h, creq_h, cwr_h;
    logic [1:0]  mbank_h, cbank_h;
    logic [3:0]  maddr_h, mbe_h, caddr_h, cbe_h;
    logic [31:0] mdata_h, cdata_h;
    logic        mack_h, cack_h, rvalid_h, rsrc_h, busy_h, err_h;
    logic [1:0]  errcode_h;
    logic [31:0] rdata_h, wbus_h, rbus_l;
    logic [3:0]  rspa_h, spw_l;
    logic        rcs_tmp_l, rcs_gpr_l, rcs_ipr_l;

    spa_seq #(.CON_STARVE(CON_STARVE)) dut (
        .clk_h(clk_h), .reset_l(reset_l),
        .mreq_h(mreq_h), .mwr_h(mwr_h), .mbank_h(mbank_h), .maddr_h(maddr_h),
        .mbe_h(mbe_h), .mdata_h(mdata_h), .mack_h(mack_h),
        .creq_h(creq_h), .cwr_h(cwr_h), .cbank_h(cbank_h), .caddr_h(caddr_h),
        .cbe_h(cbe_h), .cdata_h(cdata_h), .cack_h(cack_h),
        .rdata_h(rdata_h), .rvalid_h(rvalid_h), .rsrc_h(rsrc_h), .busy_h(busy_h),
        .err_h(err_h), .errcode_h(errcode_h), .rspa_h(rspa_h), .wbus_h(wbus_h),
        .spw_l(spw_l), .rcs_tmp_l(rcs_tmp_l), .rcs_gpr_l(rcs_gpr_l),
        .rcs_ipr_l(rcs_ipr_l), .rbus_l(rbus_l)
    );

    always #5 clk_h = ~clk_h;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_mem [4][16];
    logic [31:0] ram [4][16];
    bit          ram_ready = 1'b0;
    logic [31:0] force_one = 32'h0;
    bit          cs_conflict = 1'b0;
    bit          spw_no_cs = 1'b0;
    bit          pend = 1'b0;
    logic [1:0]  pb;
    logic [3:0]  pa, pbe;
    logic [31:0] pd;

    function automatic logic [31:0] init_word(int b, int a);
        return 32'h5A5A_0000 + 32'h1000_0000 * b + 32'h0101_0101 * a;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    // RAM read path; force_one bits are pulled low on the bus (read back as 1).
    always_comb begin
        rbus_l = 32'hFFFF_FFFF;
        if (!rcs_tmp_l)      rbus_l = ~ram[0][rspa_h];
        else if (!rcs_gpr_l) rbus_l = ~ram[1][rspa_h];
        else if (!rcs_ipr_l) rbus_l = ~ram[2][rspa_h];
        rbus_l = rbus_l & ~force_one;
    end

    // A write commits only if address and data are still held one cycle after the pulse.
    always @(negedge clk_h) begin
        int ncs;
        if (!ram_ready) begin
            for (int b = 0; b < 4; b++)
                for (int a = 0; a < 16; a++) ram[b][a] = init_word(b, a);
            ram_ready = 1'b1;
        end
        ncs = int'(!rcs_tmp_l) + int'(!rcs_gpr_l) + int'(!rcs_ipr_l);
        if (ncs > 1) cs_conflict = 1'b1;
        if (pend && rspa_h == pa && wbus_h == pd) ram[pb][pa] = merge(ram[pb][pa], pd, pbe);
        pend = 1'b0;
        if (spw_l != 4'hF) begin
            if (ncs != 1) spw_no_cs = 1'b1;
            else begin
                pend = 1'b1;
                pb   = !rcs_tmp_l ? 2'd0 : (!rcs_gpr_l ? 2'd1 : 2'd2);
                pa   = rspa_h;
                pd   = wbus_h;
                pbe  = ~spw_l;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic op(input bit con, input bit wr, input logic [1:0] bank, input logic [3:0] addr,
                      input logic [3:0] be, input logic [31:0] data);
        bit          ill, vfy, mism;
        int          lat;
        logic [31:0] want, newv, mask;
        logic [2:0]  exp_cs;
        logic [3:0]  exp_spw;
        bit          cs_on;
        ill  = (bank == 2'b11);
        vfy  = VFY && wr && !ill && (be != 4'b0000);
        mism = 1'b0;
        want = 32'h0;
        if (con) begin
            creq_h = 1; cwr_h = wr; cbank_h = bank; caddr_h = addr; cbe_h = be; cdata_h = data;
        end else begin
            mreq_h = 1; mwr_h = wr; mbank_h = bank; maddr_h = addr; mbe_h = be; mdata_h = data;
        end
        @(negedge clk_h);
        check("ack", {30'd0, mack_h, cack_h}, con ? 32'd1 : 32'd2);
        check("idle_strobes", {25'd0, rcs_tmp_l, rcs_gpr_l, rcs_ipr_l, spw_l}, 32'h7F);
        @(posedge clk_h); #1;
        mreq_h = 0; creq_h = 0;
        if (!ill && !wr) want = exp_mem[bank][addr] | force_one;
        if (!ill && wr) begin
            newv = merge(exp_mem[bank][addr], data, be);
            mask = merge(32'h0, 32'hFFFF_FFFF, be);
            mism = vfy && ((((newv | force_one) ^ data) & mask) != 0);
            exp_mem[bank][addr] = newv;
        end
        lat = ill ? 1 : (!wr ? 3 : (vfy ? 6 : 4));
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk_h);
            cs_on   = !ill && ((!wr && k <= 2) || (wr && k == 2) || (vfy && (k == 4 || k == 5)));
            exp_cs  = cs_on ? ~(3'b100 >> bank) : 3'b111;
            exp_spw = (wr && !ill && k == 2) ? ~be : 4'hF;
            check("strobes", {25'd0, rcs_tmp_l, rcs_gpr_l, rcs_ipr_l, spw_l}, {25'd0, exp_cs, exp_spw});
            if (k < lat) begin
                check("mid_flags", {29'd0, busy_h, rvalid_h, err_h}, 32'd4);
                check("rspa", {28'd0, rspa_h}, {28'd0, addr});
                if (wr) check("wbus", wbus_h, data);
            end else begin
                check("end_flags", {29'd0, busy_h, rvalid_h, err_h},
                      {29'd0, 1'b0, !wr && !ill, ill || mism});
                if (!wr && !ill) begin
                    check("rdata", rdata_h, want);
                    check("rsrc_rd", {31'd0, rsrc_h}, {31'd0, con});
                end
                if (ill || mism) begin
                    check("errcode", {30'd0, errcode_h}, ill ? 32'd1 : 32'd2);
                    check("rsrc_err", {31'd0, rsrc_h}, {31'd0, con});
                end
            end
        end
        @(posedge clk_h); #1;
        $display("op src=%0d wr=%0d bank=%0d addr=%0d be=%b data=%h lat=%0d", con, wr, bank, addr, be, data, lat);
    endtask

    initial begin
        int          ngr, cyc;
        logic [31:0] old;
        reset_l = 0;
        mreq_h = 0; mwr_h = 0; mbank_h = 0; maddr_h = 0; mbe_h = 0; mdata_h = 0;
        creq_h = 0; cwr_h = 0; cbank_h = 0; caddr_h = 0; cbe_h = 0; cdata_h = 0;
        for (int b = 0; b < 4; b++)
            for (int a = 0; a < 16; a++) exp_mem[b][a] = init_word(b, a);
        repeat (2) @(posedge clk_h);
        @(negedge clk_h);
        check("rst_strobes", {25'd0, rcs_tmp_l, rcs_gpr_l, rcs_ipr_l, spw_l}, 32'h7F);
        check("rst_rspa", {28'd0, rspa_h}, 32'd0);
        check("rst_wbus", wbus_h, 32'd0);
        check("rst_rdata", rdata_h, 32'd0);
        check("rst_flags", {24'd0, busy_h, rvalid_h, err_h, errcode_h, rsrc_h, mack_h, cack_h}, 32'd0);
        @(posedge clk_h); #1;
        reset_l = 1;

        op(0, 1, 2'b01, 4'd5, 4'hF, 32'hDEADBEEF);
        op(0, 0, 2'b01, 4'd5, 4'hF, 32'h0);
        check("rd_deadbeef", rdata_h, 32'hDEADBEEF);
        op(0, 1, 2'b01, 4'd5, 4'b0101, 32'h11223344);
        op(1, 0, 2'b01, 4'd5, 4'hF, 32'h0);
        check("rd_merge", rdata_h, 32'hDE22BE44);
        op(1, 0, 2'b11, 4'd3, 4'hF, 32'h0);
        op(0, 1, 2'b10, 4'd7, 4'b0000, 32'hCAFEF00D);
        op(1, 0, 2'b10, 4'd7, 4'hF, 32'h0);
        force_one = 32'h1;
        op(0, 1, 2'b00, 4'd2, 4'b0001, 32'h0);
        force_one = 32'h0;

        for (int i = 0; i < 40; i++)
            op(1'($urandom), 1'($urandom), 2'($urandom), 4'($urandom), 4'($urandom), $urandom);

        // Both requesters held: console must take every (CON_STARVE+1)th grant.
        mreq_h = 1; mwr_h = 0; mbank_h = 2'b00; maddr_h = 4'd1;
        creq_h = 1; cwr_h = 0; cbank_h = 2'b01; caddr_h = 4'd2;
        ngr = 0; cyc = 0;
        while (ngr < 10 && cyc < 200) begin
            @(negedge clk_h);
            cyc++;
            if (mack_h || cack_h) begin
                check("starve_grant", {30'd0, mack_h, cack_h},
                      ((ngr % (CON_STARVE + 1)) == CON_STARVE) ? 32'd1 : 32'd2);
                $display("grant %0d: %s", ngr, cack_h ? "C" : "M");
                ngr++;
            end
        end
        check("starve_count", ngr, 32'd10);
        @(posedge clk_h); #1;
        mreq_h = 0; creq_h = 0;
        repeat (4) @(posedge clk_h);
        #1;
        check("starve_idle", {31'd0, busy_h}, 32'd0);

        // Reset while the write pulse is active.
        old = exp_mem[1][5];
        mreq_h = 1; mwr_h = 1; mbank_h = 2'b01; maddr_h = 4'd5; mbe_h = 4'hF; mdata_h = ~old;
        @(negedge clk_h);
        check("rstw_ack", {31'd0, mack_h}, 32'd1);
        @(posedge clk_h); #1;
        mreq_h = 0;
        @(negedge clk_h);
        @(negedge clk_h);
        check("rstw_pulse", {25'd0, rcs_tmp_l, rcs_gpr_l, rcs_ipr_l, spw_l}, 32'h50);
        reset_l = 0;
        @(posedge clk_h); #1;
        check("rstw_strobes", {25'd0, rcs_tmp_l, rcs_gpr_l, rcs_ipr_l, spw_l}, 32'h7F);
        check("rstw_busy", {31'd0, busy_h}, 32'd0);
        @(negedge clk_h);
        check("rstw_noresp", {30'd0, rvalid_h, err_h}, 32'd0);
        @(posedge clk_h); #1;
        reset_l = 1;
        $display("reset during write pulse applied");
        op(0, 0, 2'b01, 4'd5, 4'hF, 32'h0);
        check("rstw_keep", rdata_h, old);

        check("cs_exclusive", {31'd0, cs_conflict}, 32'd0);
        check("spw_with_cs", {31'd0, spw_no_cs}, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
